stage_mem: RTL and testbench

- Memory-access stage of the 5-stage RISC-V core. Sits between the EX/MEM register and the write-back stage.
- Issues load/store requests to the data-memory port using a req/ready handshake.
- Aligns and extends load data, and builds store byte strobes.
- Owns the MEM/WB pipeline register that feeds the write-back mux.
- Raises a stall to the upstream stages while an access is outstanding.

---
 rtl/stage_mem.sv | 170 +++++++++++++++++
 tb/tb_stage_mem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// Memory-access stage: data-memory handshake, load/store lane formatting and the MEM/WB register.
// Define MEM_MISALIGN_CHECK_EN to retire misaligned accesses without a request and pulse mem_misalign.
module stage_mem #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic        ex_mem_memtoreg,
  input  logic        ex_mem_regwrite,
  input  logic [4:0]  ex_mem_rd,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rs2_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        mem_misalign,
  output logic        mem_wb_valid,
  output logic        mem_wb_regwrite,
  output logic        mem_wb_memtoreg,
  output logic [4:0]  mem_wb_rd,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_mem_read_data
);

  localparam int unsigned CntW = 16;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        mem_op, misalign, acc, abort, done;
  logic [1:0]  lane, size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data, rdata_d;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;

  assign lane   = ex_mem_alu_result[1:0];
  assign size   = ex_mem_funct3[1:0];
  assign mem_op = ~rst & ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op & (((size == 2'b01) & lane[0]) | (size[1] & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign acc   = mem_op & ~misalign;
  // Ready in the final allowed cycle wins over the abort.
  assign abort = (state_q == StWait) & acc & ~dmem_ready & (cnt_q == TIMEOUT[CntW-1:0]);
  assign done  = acc & dmem_ready;

  assign dmem_req   = acc & ~abort;
  assign mem_stall  = acc & ~dmem_ready & ~abort;
  assign dmem_we    = ~rst & ex_mem_memwrite;
  assign dmem_addr  = rst ? 32'h0 : {ex_mem_alu_result[31:2], 2'b00};
  assign dmem_wdata = rst ? 32'h0 : st_wdata;
  assign dmem_wstrb = (~rst & ex_mem_memwrite) ? st_strb : 4'b0000;

  always_comb begin
    st_wdata = ex_mem_rs2_data;
    st_strb  = 4'b1111;
    case (size)
      2'b00: begin
        st_wdata = {4{ex_mem_rs2_data[7:0]}};
        st_strb  = 4'b0001 << lane;
      end
      2'b01: begin
        st_wdata = {2{ex_mem_rs2_data[15:0]}};
        st_strb  = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (lane)
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      2'b11:   ld_byte = dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ex_mem_funct3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = dmem_rdata;
    endcase
    rdata_d = (done & ex_mem_memread) ? load_data : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (acc & ~dmem_ready) begin
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        if (~acc | dmem_ready | abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While stalled a bubble enters WB so the stalled instruction never writes twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err              <= 1'b0;
      mem_misalign         <= 1'b0;
      mem_wb_valid         <= 1'b0;
      mem_wb_regwrite      <= 1'b0;
      mem_wb_memtoreg      <= 1'b0;
      mem_wb_rd            <= 5'd0;
      mem_wb_alu_result    <= 32'h0;
      mem_wb_mem_read_data <= 32'h0;
    end else begin
      mem_err      <= abort;
      mem_misalign <= misalign;
      if (mem_stall) begin
        mem_wb_valid    <= 1'b0;
        mem_wb_regwrite <= 1'b0;
      end else begin
        mem_wb_valid         <= ex_mem_valid;
        mem_wb_regwrite      <= ex_mem_regwrite & ~abort & ~misalign;
        mem_wb_memtoreg      <= ex_mem_memtoreg;
        mem_wb_rd            <= ex_mem_rd;
        mem_wb_alu_result    <= ex_mem_alu_result;
        mem_wb_mem_read_data <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: stimulus queues expected MEM/WB entries, a monitor retires them.
module tb_stage_mem;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_mem_valid = 1'b0, ex_mem_memread = 1'b0, ex_mem_memwrite = 1'b0;
  logic        ex_mem_memtoreg = 1'b0, ex_mem_regwrite = 1'b0;
  logic [4:0]  ex_mem_rd = '0;
  logic [2:0]  ex_mem_funct3 = '0;
  logic [31:0] ex_mem_alu_result = '0, ex_mem_rs2_data = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_wstrb;
  logic        mem_stall, mem_err, mem_misalign;
  logic        mem_wb_valid, mem_wb_regwrite, mem_wb_memtoreg;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_alu_result, mem_wb_mem_read_data;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  stage_mem #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_err(mem_err), .mem_misalign(mem_misalign),
    .mem_wb_valid(mem_wb_valid), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_memtoreg(mem_wb_memtoreg), .mem_wb_rd(mem_wb_rd),
    .mem_wb_alu_result(mem_wb_alu_result), .mem_wb_mem_read_data(mem_wb_mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_mem_valid = 0; ex_mem_memread = 0; ex_mem_memwrite = 0;
    ex_mem_memtoreg = 0; ex_mem_regwrite = 0; dmem_ready = 0;
  endtask

  // Issues one instruction at posedge+1; ready rises after wait_n stall cycles (if fin_rdy).
  task automatic run(input logic mr, input logic mw, input logic m2r, input logic rw,
                     input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] rs2, input logic [31:0] rdata, input int wait_n,
                     input logic fin_rdy, input logic exp_req, input logic [3:0] exp_strb,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                     input logic exp_rw, input logic exp_err, input logic exp_mis);
    exp_t e;
    int   stalls = 0;
    logic ab = exp_req && !fin_rdy && (wait_n == int'(TO));
    ex_mem_valid = 1; ex_mem_memread = mr; ex_mem_memwrite = mw; ex_mem_memtoreg = m2r;
    ex_mem_regwrite = rw; ex_mem_rd = rd; ex_mem_funct3 = f3; ex_mem_alu_result = addr;
    ex_mem_rs2_data = rs2; dmem_rdata = rdata;
    dmem_ready = (wait_n == 0) ? fin_rdy : 1'b0;
    e.rw = exp_rw; e.m2r = m2r; e.rd = rd; e.alu = addr; e.data = exp_data;
    e.err = exp_err; e.mis = exp_mis;
    sb_q.push_back(e);
    #3;
    chk("req_first", dmem_req, exp_req);
    if (exp_req) begin
      chk("addr", dmem_addr, {addr[31:2], 2'b00});
      chk("we", dmem_we, mw);
      chk("wstrb", dmem_wstrb, exp_strb);
      if (mw) chk("wdata", dmem_wdata, exp_wdata);
    end
    for (int c = 0; c <= wait_n; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        dmem_ready = (c == wait_n) ? fin_rdy : 1'b0;
        #3;
      end
      if (mem_stall) stalls++;
      if (c == wait_n) chk("req_final", dmem_req, exp_req & !ab);
    end
    chk("stall_cycles", stalls, wait_n);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Monitor: every MEM/WB retirement must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_wb_valid) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: retired rd %0d with no entry expected", mem_wb_rd);
          end else begin
            e = sb_q.pop_front();
            chk("wb_regwrite", mem_wb_regwrite, e.rw);
            chk("wb_memtoreg", mem_wb_memtoreg, e.m2r);
            chk("wb_rd", mem_wb_rd, e.rd);
            chk("wb_alu", mem_wb_alu_result, e.alu);
            chk("wb_rdata", mem_wb_mem_read_data, e.data);
            chk("wb_err", mem_err, e.err);
            chk("wb_misalign", mem_misalign, e.mis);
          end
        end else begin
          chk("err_idle", mem_err, 1'b0);
          chk("misalign_idle", mem_misalign, 1'b0);
        end
      end
    end
  end

  initial begin
    // Reset state, with a pending load on the inputs to show the request is gated.
    ex_mem_valid = 1; ex_mem_memread = 1;
    #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_wb_valid", mem_wb_valid, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    //   mr mw m2r rw rd     f3      addr          rs2           rdata         wait rdy req strb   wdata         data          rw err mis
    run(1, 0, 1, 1, 5'd5,  3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,   1, 1, 4'h0, 32'h0,        32'hDEAD_BEEF, 1, 0, 0);
    run(1, 0, 1, 1, 5'd6,  3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 3,   1, 1, 4'h0, 32'h0,        32'hFFFF_FF80, 1, 0, 0);
    run(1, 0, 1, 1, 5'd7,  3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 0,   1, 1, 4'h0, 32'h0,        32'h0000_0080, 1, 0, 0);
    run(1, 0, 1, 1, 5'd8,  3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1,   1, 1, 4'h0, 32'h0,        32'hFFFF_8001, 1, 0, 0);
    run(1, 0, 1, 1, 5'd9,  3'b101, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0,   1, 1, 4'h0, 32'h0,        32'h0000_F00D, 1, 0, 0);
    run(1, 0, 1, 1, 5'd10, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0,   1, 1, 4'h0, 32'h0,        32'h0000_007F, 1, 0, 0);
    run(1, 0, 1, 1, 5'd11, 3'b011, 32'h0000_0108, 32'h0,        32'h0BAD_CAFE, 0,   1, 1, 4'h0, 32'h0,        32'h0BAD_CAFE, 1, 0, 0);
    run(0, 1, 0, 0, 5'd0,  3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'h0,        0,   1, 1, 4'hC, 32'hABCD_ABCD, 32'h0,        0, 0, 0);
    run(0, 1, 0, 0, 5'd0,  3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        2,   1, 1, 4'h2, 32'hA5A5_A5A5, 32'h0,        0, 0, 0);
    run(0, 1, 0, 0, 5'd0,  3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        0,   1, 1, 4'hF, 32'hCAFE_F00D, 32'h0,        0, 0, 0);
    // Plain ALU op with ready low: no request, no stall, passes in one cycle.
    run(0, 0, 0, 1, 5'd12, 3'b000, 32'h1234_5678, 32'h0,        32'h0,        0,   0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 0);
    // Timeout abort, then ready arriving on the timeout cycle.
    run(1, 0, 1, 1, 5'd13, 3'b010, 32'h0000_0500, 32'h0,        32'h5555_5555, 4,   0, 1, 4'h0, 32'h0,        32'h0,        0, 1, 0);
    run(1, 0, 1, 1, 5'd14, 3'b010, 32'h0000_0504, 32'h0,        32'h1111_2222, 4,   1, 1, 4'h0, 32'h0,        32'h1111_2222, 1, 0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    run(1, 0, 1, 1, 5'd15, 3'b010, 32'h0000_0102, 32'h0,        32'hAABB_CCDD, 0,   0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 1);
`else
    run(1, 0, 1, 1, 5'd15, 3'b010, 32'h0000_0102, 32'h0,        32'hAABB_CCDD, 0,   1, 1, 4'h0, 32'h0,        32'hAABB_CCDD, 1, 0, 0);
`endif

    // Bubble carrying memread: no request, nothing retires.
    ex_mem_valid = 0; ex_mem_memread = 1; ex_mem_alu_result = 32'h700;
    #3 chk("bubble_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    idle_inputs();

    // Reset while in WAIT, then the same load reissues from scratch.
    ex_mem_valid = 1; ex_mem_memread = 1; ex_mem_memtoreg = 1; ex_mem_regwrite = 1;
    ex_mem_rd = 5'd20; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h600;
    dmem_rdata = 32'h0BAD_F00D; dmem_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rstw_req", dmem_req, 1'b0);
    chk("rstw_stall", mem_stall, 1'b0);
    chk("rstw_wb_valid", mem_wb_valid, 1'b0);
    chk("rstw_wb_regwrite", mem_wb_regwrite, 1'b0);
    chk("rstw_wb_memtoreg", mem_wb_memtoreg, 1'b0);
    chk("rstw_wb_rd", mem_wb_rd, 5'd0);
    chk("rstw_wb_alu", mem_wb_alu_result, 32'h0);
    chk("rstw_wb_rdata", mem_wb_mem_read_data, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    sb_q.push_back('{rw: 1'b1, m2r: 1'b1, rd: 5'd20, alu: 32'h600, data: 32'h0BAD_F00D,
                     err: 1'b0, mis: 1'b0});
    #3;
    chk("reissue_req", dmem_req, 1'b1);
    chk("reissue_stall", mem_stall, 1'b1);
    @(posedge clk); #1;
    dmem_ready = 1;
    #3 chk("reissue_done_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    idle_inputs();

    repeat (3) @(posedge clk);
    #1 chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
